// File: rtl/sysarr_job_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sysarr_job_sched
//  Purpose  : Shares one NxN systolic matmul array between two requesters.
//             Round-robin picks a job, holds its operands on the array,
//             pulses the element valids for one cycle, waits for the array
//             result (or a timeout), then returns it on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module sysarr_job_sched #(
   parameter int N            = 3,
   parameter int DATA_WIDTH   = 8,
   parameter int OUTPUT_WIDTH = 16,
   parameter int TIMEOUT      = 64,
   parameter int CW           = $clog2(TIMEOUT + 1)
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [0:1]                                        req_valid_i,
   output logic [0:1]                                        req_ready_o,
   input  logic [0:1][0:N-1][0:N-1][DATA_WIDTH-1:0]          req_a_i,
   input  logic [0:1][0:N-1][0:N-1][DATA_WIDTH-1:0]          req_b_i,
   output logic [0:N-1][0:N-1][DATA_WIDTH-1:0]               arr_a_o,
   output logic [0:N-1][0:N-1][DATA_WIDTH-1:0]               arr_b_o,
   output logic [0:N-1][0:N-1]                               arr_valid_a_o,
   output logic [0:N-1][0:N-1]                               arr_valid_b_o,
   input  logic [0:N-1][0:N-1][OUTPUT_WIDTH-1:0]             arr_c_i,
   input  logic                                              arr_valid_out_i,
   output logic                                              res_valid_o,
   input  logic                                              res_ready_i,
   output logic                                              res_id_o,
   output logic [0:N-1][0:N-1][OUTPUT_WIDTH-1:0]             res_c_o,
   output logic                                              res_err_o,
   output logic [CW-1:0]                                     res_cycles_o,
   output logic                                              busy_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [1:0]                                   state_q,  state_d;
   logic                                         rr_ptr_q, rr_ptr_d;
   logic                                         id_q,     id_d;
   logic [CW-1:0]                                cnt_q,    cnt_d;
   logic [0:N-1][0:N-1][DATA_WIDTH-1:0]          arr_a_q,  arr_a_d;
   logic [0:N-1][0:N-1][DATA_WIDTH-1:0]          arr_b_q,  arr_b_d;
   logic [0:N-1][0:N-1][OUTPUT_WIDTH-1:0]        res_c_q,  res_c_d;
   logic                                         err_q,    err_d;
   logic [CW-1:0]                                cyc_q,    cyc_d;

   logic grant_any;
   logic grant;

   // Arbitration: a lone requester wins outright; on contention rr_ptr decides.
   always_comb begin
      grant_any = (state_q == S_IDLE) && (req_valid_i[0] || req_valid_i[1]);
      grant     = (req_valid_i[0] && req_valid_i[1]) ? rr_ptr_q : req_valid_i[1];
   end

   // Next-state logic for the job FSM and every datapath register.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      arr_a_d  = arr_a_q;
      arr_b_d  = arr_b_q;
      res_c_d  = res_c_q;
      err_d    = err_q;
      cyc_d    = cyc_q;
      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               arr_a_d  = req_a_i[grant];
               arr_b_d  = req_b_i[grant];
               id_d     = grant;
               rr_ptr_d = ~grant;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_ONE;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the timeout cycle still counts as success.
            if (arr_valid_out_i) begin
               res_c_d = arr_c_i;
               cyc_d   = cnt_q;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == TIMEOUT_C) begin
               res_c_d = '0;
               cyc_d   = cnt_q;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_RESP: begin
            if (res_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset also abandons any in-flight job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= 1'b0;
         id_q     <= 1'b0;
         cnt_q    <= '0;
         arr_a_q  <= '0;
         arr_b_q  <= '0;
         res_c_q  <= '0;
         err_q    <= 1'b0;
         cyc_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
         arr_a_q  <= arr_a_d;
         arr_b_q  <= arr_b_d;
         res_c_q  <= res_c_d;
         err_q    <= err_d;
         cyc_q    <= cyc_d;
      end
   end

   // Outputs decode directly from registered state, so they are glitch-free
   // apart from req_ready, which must respond in the same cycle as req_valid.
   always_comb begin
      req_ready_o[0] = grant_any && !grant;
      req_ready_o[1] = grant_any &&  grant;
      arr_a_o        = arr_a_q;
      arr_b_o        = arr_b_q;
      arr_valid_a_o  = {(N*N){state_q == S_ISSUE}};
      arr_valid_b_o  = {(N*N){state_q == S_ISSUE}};
      res_valid_o    = (state_q == S_RESP);
      res_id_o       = id_q;
      res_c_o        = res_c_q;
      res_err_o      = err_q;
      res_cycles_o   = cyc_q;
      busy_o         = (state_q != S_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_sysarr_job_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sysarr_job_sched
//  Purpose  : Self-checking bench for sysarr_job_sched with a behavioural
//             array model and a round-robin/job-outcome reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sysarr_job_sched;

   localparam int N  = 3;
   localparam int DW = 8;
   localparam int OW = 16;
   localparam int TO = 64;
   localparam int CW = $clog2(TO + 1);

   typedef logic [0:N-1][0:N-1][DW-1:0] mat_t;
   typedef logic [0:N-1][0:N-1][OW-1:0] res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [0:1]                       req_valid;
   logic [0:1]                       req_ready;
   logic [0:1][0:N-1][0:N-1][DW-1:0] req_a;
   logic [0:1][0:N-1][0:N-1][DW-1:0] req_b;
   mat_t                             arr_a, arr_b;
   logic [0:N-1][0:N-1]              va, vb;
   res_t                             arr_c;
   logic                             arr_valid_out;
   logic                             res_valid, res_ready, res_id;
   res_t                             res_c;
   logic                             res_err;
   logic [CW-1:0]                    res_cycles;
   logic                             busy;

   sysarr_job_sched #(
      .N(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .TIMEOUT(TO), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_a_i(req_a), .req_b_i(req_b),
      .arr_a_o(arr_a), .arr_b_o(arr_b),
      .arr_valid_a_o(va), .arr_valid_b_o(vb),
      .arr_c_i(arr_c), .arr_valid_out_i(arr_valid_out),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
      .res_c_o(res_c), .res_err_o(res_err), .res_cycles_o(res_cycles),
      .busy_o(busy)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int m_ptr    = 0;   // reference round-robin pointer

   res_t          last_c;
   logic          last_id;
   logic          last_err;
   logic [CW-1:0] last_cyc;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic res_t matmul(input mat_t a, input mat_t b);
      res_t r;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int s = 0;
            for (int k = 0; k < N; k++) s += int'(a[i][k]) * int'(b[k][j]);
            r[i][j] = OW'(s);
         end
      return r;
   endfunction

   function automatic mat_t rmat();
      mat_t m;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) m[i][j] = DW'($urandom_range(0, 255));
      return m;
   endfunction

   function automatic res_t rres();
      res_t m;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) m[i][j] = OW'($urandom_range(0, 65535));
      return m;
   endfunction

   function automatic int exp_grant(input logic [0:1] v);
      if (v[0] && v[1]) return m_ptr;
      if (v[1])         return 1;
      return 0;
   endfunction

   task automatic check_reset;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_arr_a", arr_a, 0);
      chk("rst_arr_b", arr_b, 0);
      chk("rst_valid_a", va, 0);
      chk("rst_valid_b", vb, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_c", res_c, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_res_cycles", res_cycles, 0);
      chk("rst_busy", busy, 0);
   endtask

   task automatic stray_idle;
      req_valid     = 2'b00;
      arr_valid_out = 1'b1;
      arr_c         = rres();
      step;
      arr_valid_out = 1'b0;
      #1;
      chk("stray_idle_busy", busy, 0);
      chk("stray_idle_res_valid", res_valid, 0);
      chk("stray_idle_res_c", res_c, last_c);
      chk("stray_idle_res_id", res_id, last_id);
      chk("stray_idle_res_err", res_err, last_err);
      chk("stray_idle_res_cycles", res_cycles, last_cyc);
   endtask

   // One complete job. Entered just after a clock edge with the DUT idle and
   // req_valid already driven. lat = array latency after ISSUE (0 = never).
   task automatic run_job(input int lat, input int bp, input bit keep, input bit stray);
      int         g;
      int         ecyc;
      logic       eerr;
      mat_t       ea, eb;
      res_t       ec;
      logic [0:1] er;
      #1;
      g     = exp_grant(req_valid);
      er    = 2'b00;
      er[g] = 1'b1;
      chk("accept_req_ready", req_ready, er);
      chk("accept_busy", busy, 0);
      ea    = req_a[g];
      eb    = req_b[g];
      m_ptr = 1 - g;
      if (lat >= 1 && lat <= TO) begin
         ecyc = lat; eerr = 1'b0; ec = matmul(ea, eb);
      end else begin
         ecyc = TO;  eerr = 1'b1; ec = '0;
      end

      step;  // accept edge: ISSUE cycle now
      if (!keep) req_valid[g] = 1'b0;
      req_a[g] = rmat();
      req_b[g] = rmat();
      #1;
      chk("issue_valid_a", va, {(N*N){1'b1}});
      chk("issue_valid_b", vb, {(N*N){1'b1}});
      chk("issue_arr_a", arr_a, ea);
      chk("issue_arr_b", arr_b, eb);
      chk("issue_busy", busy, 1);
      chk("issue_req_ready", req_ready, 0);

      for (int c = 1; c <= ecyc; c++) begin
         step;
         if (c == lat) begin
            arr_valid_out = 1'b1;
            arr_c         = matmul(ea, eb);
         end
         #1;
         chk("wait_valid_a", va, 0);
         chk("wait_valid_b", vb, 0);
         chk("wait_arr_a", arr_a, ea);
         chk("wait_arr_b", arr_b, eb);
         chk("wait_res_valid", res_valid, 0);
         chk("wait_req_ready", req_ready, 0);
      end

      step;  // first RESP cycle
      arr_valid_out = 1'b0;
      #1;
      chk("resp_valid", res_valid, 1);
      chk("resp_id", res_id, g);
      chk("resp_c", res_c, ec);
      chk("resp_err", res_err, eerr);
      chk("resp_cycles", res_cycles, ecyc);
      chk("resp_req_ready", req_ready, 0);

      for (int c = 0; c < bp; c++) begin
         if (stray && c == 0) begin
            arr_valid_out = 1'b1;
            arr_c         = ~ec;
         end
         step;
         arr_valid_out = 1'b0;
         #1;
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_id", res_id, g);
         chk("bp_res_c", res_c, ec);
         chk("bp_res_err", res_err, eerr);
         chk("bp_res_cycles", res_cycles, ecyc);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_arr_a", arr_a, ea);
      end

      res_ready = 1'b1;
      #1;
      chk("hs_req_ready", req_ready, 0);
      step;  // handshake edge: back to IDLE
      res_ready = 1'b0;
      #1;
      chk("post_res_valid", res_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_arr_a_kept", arr_a, ea);
      chk("post_arr_b_kept", arr_b, eb);
      last_c   = ec;
      last_id  = g[0];
      last_err = eerr;
      last_cyc = CW'(ecyc);
   endtask

   initial begin
      int v;
      req_valid     = 2'b00;
      req_a         = '0;
      req_b         = '0;
      arr_c         = '0;
      arr_valid_out = 1'b0;
      res_ready     = 1'b0;
      last_c        = '0;
      last_id       = 1'b0;
      last_err      = 1'b0;
      last_cyc      = '0;
      rst           = 1'b1;
      step;
      step;
      rst = 1'b0;
      #1;
      check_reset;
      stray_idle;

      // Contention from reset: both held high, expect grants 0,1,0,1.
      req_a[0] = rmat(); req_b[0] = rmat();
      req_a[1] = rmat(); req_b[1] = rmat();
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++)
         run_job($urandom_range(1, 20), (k == 1) ? 10 : $urandom_range(0, 3), 1'b1, k == 1);
      stray_idle;

      // Single directed job: identity times 1..9.
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            req_a[0][i][j] = (i == j) ? DW'(1) : DW'(0);
            req_b[0][i][j] = DW'(i * N + j + 1);
         end
      req_valid    = 2'b00;
      req_valid[0] = 1'b1;
      run_job(7, 0, 1'b0, 1'b0);

      // Timeout: array never answers.
      req_valid    = 2'b00;
      req_valid[1] = 1'b1;
      run_job(0, 2, 1'b0, 1'b1);

      // Result arriving on the timeout cycle wins.
      req_valid    = 2'b00;
      req_valid[0] = 1'b1;
      run_job(TO, 0, 1'b0, 1'b0);

      // Reset during WAIT cycle 3, leaving the DUT's pointer at 1 beforehand.
      req_a[0]     = rmat(); req_b[0] = rmat();
      req_valid    = 2'b00;
      req_valid[0] = 1'b1;
      #1;
      chk("rstjob_req_ready", req_ready, 2'b10);
      step;
      req_valid = 2'b00;
      step;
      step;
      step;
      chk("rstjob_busy_wait", busy, 1);
      rst = 1'b1;
      step;
      rst = 1'b0;
      #1;
      check_reset;
      m_ptr    = 0;
      last_c   = '0;
      last_id  = 1'b0;
      last_err = 1'b0;
      last_cyc = '0;
      arr_valid_out = 1'b1;
      arr_c         = rres();
      step;
      arr_valid_out = 1'b0;
      #1;
      chk("late_valid_busy", busy, 0);
      chk("late_valid_res_valid", res_valid, 0);
      chk("late_valid_res_c", res_c, 0);
      req_a[0] = rmat(); req_b[0] = rmat();
      req_a[1] = rmat(); req_b[1] = rmat();
      req_valid = 2'b11;
      run_job($urandom_range(1, 12), 0, 1'b0, 1'b0);

      // Randomized jobs.
      for (int k = 0; k < 8; k++) begin
         v         = $urandom_range(1, 3);
         req_valid = v[1:0];
         req_a[0] = rmat(); req_b[0] = rmat();
         req_a[1] = rmat(); req_b[1] = rmat();
         run_job($urandom_range(1, 30), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         stray_idle;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
